// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters: zero-latency fetch
// lookup, execute-stage mispredict detection, table training and perf counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] F_PC,
    output logic            F_PredTaken,
    output logic [XLEN-1:0] F_PredTarget,
    input  logic            E_Valid,
    input  logic            E_Branch,
    input  logic            E_Jump,
    input  logic            E_PCSrc,
    input  logic [XLEN-1:0] E_PC,
    input  logic [XLEN-1:0] E_Target,
    input  logic            E_PredTaken,
    input  logic [XLEN-1:0] E_PredTarget,
    output logic            E_Mispredict,
    output logic [XLEN-1:0] E_RedirectPC,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] is_jump_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [IDX-1:0]  e_idx;
    logic [TAGW-1:0] e_tag;
    logic            e_hit;
    logic            ctl;

    // PC bits [1:0] never index or tag the table
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_PC[1:0], E_PC[1:0]};

    assign f_idx = F_PC[IDX+1:2];
    assign f_tag = F_PC[XLEN-1:IDX+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign e_idx = E_PC[IDX+1:2];
    assign e_tag = E_PC[XLEN-1:IDX+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign ctl = E_Valid && (E_Branch || E_Jump);

    assign F_PredTaken  = f_hit && (is_jump_q[f_idx] || ctr_q[f_idx][1]);
    assign F_PredTarget = F_PredTaken ? target_q[f_idx] : '0;

    always_comb begin
        E_Mispredict = 1'b0;
        if (ctl) begin
            E_Mispredict = (E_PCSrc != E_PredTaken) ||
                           (E_PCSrc && E_PredTaken && (E_Target != E_PredTarget));
        end else if (E_Valid && E_PredTaken) begin
            E_Mispredict = 1'b1;
        end
    end

    assign E_RedirectPC = (ctl && E_PCSrc) ? E_Target : (E_PC + XLEN'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (ctl) begin
                if (e_hit) begin
                    if (E_PCSrc) begin
                        if (E_Jump || ctr_q[e_idx] == 2'b11) begin
                            ctr_q[e_idx] <= 2'b11;
                        end else begin
                            ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                        end
                    end else if (!is_jump_q[e_idx] && ctr_q[e_idx] != 2'b00) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                    end
                end else if (E_PCSrc) begin
                    valid_q[e_idx] <= 1'b1;
                    ctr_q[e_idx]   <= E_Jump ? 2'b11 : 2'b10;
                end
            end else if (E_Valid && E_PredTaken && e_hit) begin
                // a non-control instruction was predicted taken: drop the aliasing entry
                valid_q[e_idx] <= 1'b0;
            end

            if (ctl && branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (E_Mispredict && mispred_cnt != '1) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    // tag/target/kind are only meaningful behind valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (!rst && ctl && E_PCSrc) begin
            tag_q[e_idx]     <= e_tag;
            target_q[e_idx]  <= E_Target;
            is_jump_q[e_idx] <= E_Jump;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic checked
// against a behavioural table model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX     = 4;

    logic        clk;
    logic        rst;
    logic [31:0] F_PC;
    logic        F_PredTaken;
    logic [31:0] F_PredTarget;
    logic        E_Valid, E_Branch, E_Jump, E_PCSrc, E_PredTaken;
    logic [31:0] E_PC, E_Target, E_PredTarget;
    logic        E_Mispredict;
    logic [31:0] E_RedirectPC;
    logic [31:0] branch_cnt, mispred_cnt;

    branch_predictor #(.ENTRIES(ENTRIES), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .F_PC(F_PC), .F_PredTaken(F_PredTaken), .F_PredTarget(F_PredTarget),
        .E_Valid(E_Valid), .E_Branch(E_Branch), .E_Jump(E_Jump), .E_PCSrc(E_PCSrc),
        .E_PC(E_PC), .E_Target(E_Target), .E_PredTaken(E_PredTaken),
        .E_PredTarget(E_PredTarget), .E_Mispredict(E_Mispredict),
        .E_RedirectPC(E_RedirectPC), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: one record per table slot, counters as plain integers
    bit          m_valid [ENTRIES];
    bit          m_jump  [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_bcnt, m_mcnt;
    logic        pre_ptk;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> (2 + IDX)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_jump[slot(pc)] || m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic cycle(input bit v, input bit b, input bit j, input bit s,
                         input logic [31:0] epc, input logic [31:0] etgt,
                         input bit ptk, input logic [31:0] ptgt, input logic [31:0] fpc);
        bit ctl, misp, hit;
        int k;
        E_Valid = v; E_Branch = b; E_Jump = j; E_PCSrc = s;
        E_PC = epc; E_Target = etgt; E_PredTaken = ptk; E_PredTarget = ptgt; F_PC = fpc;
        #1;
        ctl  = v && (b || j);
        misp = 0;
        if (ctl) misp = (s != ptk) || (s && ptk && etgt != ptgt);
        else if (v && ptk) misp = 1;
        check("f_pred_taken", F_PredTaken, m_pred(fpc));
        check("f_pred_target", F_PredTarget, m_pred_tgt(fpc));
        check("e_mispredict", E_Mispredict, misp);
        check("e_redirect_pc", E_RedirectPC, (ctl && s) ? etgt : epc + 32'd4);
        check("branch_cnt", branch_cnt, m_bcnt);
        check("mispred_cnt", mispred_cnt, m_mcnt);
        pre_ptk = F_PredTaken;
        @(posedge clk);
        k   = slot(epc);
        hit = m_hit(epc);
        if (ctl) begin
            if (hit && s) begin
                m_ctr[k]  = (j || m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                m_tgt[k]  = etgt;
                m_jump[k] = j;
            end else if (hit) begin
                if (!m_jump[k] && m_ctr[k] > 0) m_ctr[k]--;
            end else if (s) begin
                m_valid[k] = 1;
                m_tag[k]   = epc >> (2 + IDX);
                m_tgt[k]   = etgt;
                m_jump[k]  = j;
                m_ctr[k]   = j ? 3 : 2;
            end
        end else if (v && ptk && hit) begin
            m_valid[k] = 0;
        end
        if (ctl && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        if (misp && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
        @(negedge clk);
    endtask

    // reset is applied with a live taken branch to show rst wins over training
    task automatic do_reset();
        rst = 1'b1;
        E_Valid = 1; E_Branch = 1; E_Jump = 0; E_PCSrc = 1;
        E_PC = 32'h100; E_Target = 32'h80; E_PredTaken = 0; E_PredTarget = 0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        E_Valid = 0;
        F_PC = 32'h100;
        #1;
        check("rst_pred_taken", F_PredTaken, 1'b0);
        check("rst_pred_target", F_PredTarget, 32'h0);
        check("rst_branch_cnt", branch_cnt, 32'h0);
        check("rst_mispred_cnt", mispred_cnt, 32'h0);
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [8];
        pool = '{32'h100, 32'h104, 32'h140, 32'h200, 32'h240, 32'h300, 32'h1100, 32'h13c};
        if ($urandom_range(0, 9) == 0) return $urandom & 32'hFFFF_FFFC;
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        rst = 1'b1;
        F_PC = 0; E_Valid = 0; E_Branch = 0; E_Jump = 0; E_PCSrc = 0;
        E_PC = 0; E_Target = 0; E_PredTaken = 0; E_PredTarget = 0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        check("idle_branch_cnt", branch_cnt, 32'h0);
        check("idle_mispred_cnt", mispred_cnt, 32'h0);

        // first taken branch allocates
        cycle(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h100);
        check("alloc_misp", E_Mispredict, 1'b1);
        check("alloc_redirect", E_RedirectPC, 32'h80);
        check("alloc_pred_taken", F_PredTaken, 1'b1);
        check("alloc_pred_target", F_PredTarget, 32'h80);

        // two not-taken resolves: 10 -> 01 -> 00
        cycle(1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        check("nt_misp", E_Mispredict, 1'b1);
        check("nt_redirect", E_RedirectPC, 32'h104);
        check("nt_pred_taken", F_PredTaken, 1'b0);
        cycle(1, 1, 0, 0, 32'h100, 32'h80, 0, 32'h0, 32'h100);
        check("nt2_misp", E_Mispredict, 1'b0);

        // saturate high then one not-taken leaves it predicting taken
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 0, 1, 32'h100, 32'h80, m_pred(32'h100), m_pred_tgt(32'h100), 32'h100);
        cycle(1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        check("sat_pred_taken", F_PredTaken, 1'b1);
        check("sat_pred_target", F_PredTarget, 32'h80);

        // jal replaces the 0x100 entry at the shared slot
        cycle(1, 0, 1, 1, 32'h200, 32'h400, 0, 32'h0, 32'h200);
        check("jal_pred_taken", F_PredTaken, 1'b1);
        check("jal_pred_target", F_PredTarget, 32'h400);
        cycle(1, 0, 0, 0, 32'h240, 32'h0, 1, 32'h400, 32'h200);
        check("nonbr_misp", E_Mispredict, 1'b1);
        check("nonbr_redirect", E_RedirectPC, 32'h244);
        // non-branch at the exact tagged PC clears the entry
        cycle(1, 0, 0, 0, 32'h200, 32'h0, 1, 32'h400, 32'h200);
        check("alias_misp", E_Mispredict, 1'b1);
        check("alias_cleared", F_PredTaken, 1'b0);

        // allocate and look up the same slot in one cycle
        cycle(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0, 32'h100);
        check("same_cycle_pre", pre_ptk, 1'b0);
        check("same_cycle_post", F_PredTaken, 1'b1);

        do_reset();

        for (int n = 0; n < 3000; n++) begin
            bit v, b, j, s, ptk;
            logic [31:0] epc, etgt, ptgt;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0: begin b = 0; j = 1; end
                1: begin b = 0; j = 0; end
                default: begin b = 1; j = 0; end
            endcase
            s    = j ? 1'b1 : 1'($urandom);
            epc  = pick_pc();
            etgt = ($urandom_range(0, 3) == 0) ? pick_pc() : (32'h80 + (epc & 32'h30));
            if ($urandom_range(0, 1) == 0) begin
                ptk  = m_pred(epc);
                ptgt = m_pred_tgt(epc);
            end else begin
                ptk  = 1'($urandom);
                ptgt = ptk ? pick_pc() : 32'h0;
            end
            cycle(v, b, j, s, epc, etgt, ptk, ptgt, pick_pc());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
